// File: rtl/gn_pkg.sv
// Shared definitions for the guess-number game: key indices, FSM encoding
// and small key-vector helpers used by the input stage and digit-entry block.
package gn_pkg;

    localparam int N_KEYS    = 5;
    localparam int KEY_I1    = 0;
    localparam int KEY_I2    = 1;
    localparam int KEY_I3    = 2;
    localparam int KEY_I4    = 3;
    localparam int KEY_ENTER = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_key(input logic [N_KEYS-1:0] keys);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_KEYS-1:0] key_onehot(input logic [2:0] idx);
        logic [N_KEYS-1:0] one;
        one = {{(N_KEYS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: two-flop synchroniser followed by a stable-count debouncer
// that only commits a new level after DEBOUNCE_CNT unchanged cycles.
module key_debounce #(
    parameter int DEBOUNCE_CNT = 250000,
    parameter int CNT_W        = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Any disagreement shorter than the full count restarts from zero, so the cap is the only exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounces the five game buttons and emits one single-cycle pulse per accepted
// press, allowing only one key to be owned at a time.
module key_pulse_conditioner
    import gn_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 250000,
    parameter int CNT_W        = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] btn_raw,
    input  logic              clr_collision,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [2:0]        key_code,
    output logic [N_KEYS-1:0] key_level,
    output logic              busy,
    output logic              collision
);

    logic [N_KEYS-1:0] level_d;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] drop;
    logic [2:0]        win_idx;
    logic [0:0]        state;
    logic [2:0]        owner;
    logic              owner_level;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .CNT_W        (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn_raw[k]),
            .level   (key_level[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= '0;
        end else begin
            level_d <= key_level;
        end
    end

    assign rise        = key_level & ~level_d;
    assign win_idx     = lowest_key(rise);
    assign owner_level = |(key_level & key_onehot(owner));
    assign busy        = (state == ST_HELD);

    // In IDLE the lowest rising key wins; every other rise is dropped and flagged.
    always_comb begin
        accept = '0;
        drop   = '0;
        if (state == ST_IDLE) begin
            if (|rise) begin
                accept = key_onehot(win_idx);
            end
            drop = rise & ~accept;
        end else begin
            drop = rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= 3'd0;
            key_pulse <= '0;
            key_code  <= 3'd0;
            collision <= 1'b0;
        end else begin
            key_pulse <= accept;
            key_code  <= (|accept) ? win_idx : 3'd0;

            if (|drop) begin
                collision <= 1'b1;
            end else if (clr_collision) begin
                collision <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (|accept) begin
                        state <= ST_HELD;
                        owner <= win_idx;
                    end
                end
                default: begin
                    if (!owner_level) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with a short debounce count of 4.
// Edge 0 is the first rising edge that samples a newly driven raw value.
module tb_key_pulse_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic       clr_collision;
    logic [4:0] key_pulse;
    logic [2:0] key_code;
    logic [4:0] key_level;
    logic       busy;
    logic       collision;

    int vectors     = 0;
    int miscompares = 0;

    key_pulse_conditioner #(
        .DEBOUNCE_CNT (4),
        .CNT_W        (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .clr_collision (clr_collision),
        .key_pulse     (key_pulse),
        .key_code      (key_code),
        .key_level     (key_level),
        .busy          (busy),
        .collision     (collision)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_pulse"}, {3'b0, key_pulse}, 8'h00);
        check_output({tag, "_code"}, {5'b0, key_code}, 8'h00);
        check_output({tag, "_level"}, {3'b0, key_level}, 8'h00);
        check_output({tag, "_busy"}, {7'b0, busy}, 8'h00);
        check_output({tag, "_coll"}, {7'b0, collision}, 8'h00);
    endtask

    initial begin
        reset         = 1'b1;
        btn_raw       = 5'b0;
        clr_collision = 1'b0;
        ticks(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single I1 press held for 20 cycles
        btn_raw = 5'b00001;
        for (int e = 0; e <= 19; e++) begin
            tick();
            if (e == 19) btn_raw = 5'b0;
            if (e <= 8) begin
                check_output("t1_level", {3'b0, key_level}, (e >= 5) ? 8'h01 : 8'h00);
                check_output("t1_pulse", {3'b0, key_pulse}, (e == 6) ? 8'h01 : 8'h00);
                check_output("t1_code", {5'b0, key_code}, 8'h00);
                check_output("t1_busy", {7'b0, busy}, (e >= 6) ? 8'h01 : 8'h00);
            end else begin
                check_output("t1_hold_pulse", {3'b0, key_pulse}, 8'h00);
            end
        end
        for (int e = 20; e <= 26; e++) begin
            tick();
            if (e == 24) begin
                check_output("t1_rel_level", {3'b0, key_level}, 8'h01);
                check_output("t1_rel_busy", {7'b0, busy}, 8'h01);
            end
            if (e == 26) begin
                check_output("t1_fall_level", {3'b0, key_level}, 8'h00);
                check_output("t1_fall_busy", {7'b0, busy}, 8'h00);
            end
        end
        ticks(3);

        // I2 glitch shorter than the debounce window
        btn_raw = 5'b00010;
        for (int e = 0; e <= 14; e++) begin
            tick();
            if (e == 2) btn_raw = 5'b0;
            check_output("t2_level", {3'b0, key_level}, 8'h00);
            check_output("t2_pulse", {3'b0, key_pulse}, 8'h00);
        end
        check_output("t2_coll", {7'b0, collision}, 8'h00);

        // Bouncing enter, steady from edge 4
        for (int e = 0; e <= 14; e++) begin
            if (e <= 3) btn_raw = (e % 2 == 0) ? 5'b10000 : 5'b00000;
            else btn_raw = 5'b10000;
            tick();
            check_output("t3_pulse", {3'b0, key_pulse}, (e == 10) ? 8'h10 : 8'h00);
            check_output("t3_code", {5'b0, key_code}, (e == 10) ? 8'h04 : 8'h00);
        end
        btn_raw = 5'b0;
        ticks(10);
        check_output("t3_idle_busy", {7'b0, busy}, 8'h00);

        // I3 and I4 together: lowest index wins, the other is a collision
        btn_raw = 5'b01100;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check_output("t4_pulse", {3'b0, key_pulse}, (e == 6) ? 8'h04 : 8'h00);
            check_output("t4_code", {5'b0, key_code}, (e == 6) ? 8'h02 : 8'h00);
        end
        check_output("t4_coll", {7'b0, collision}, 8'h01);
        check_output("t4_level", {3'b0, key_level}, 8'h0c);
        check_output("t4_busy", {7'b0, busy}, 8'h01);
        btn_raw = 5'b0;
        ticks(10);
        btn_raw = 5'b01000;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check_output("t4_i4_pulse", {3'b0, key_pulse}, (e == 6) ? 8'h08 : 8'h00);
            check_output("t4_i4_code", {5'b0, key_code}, (e == 6) ? 8'h03 : 8'h00);
        end
        btn_raw = 5'b0;
        ticks(10);

        // I2 owned, I1 pressed on top of it
        clr_collision = 1'b1;
        tick();
        clr_collision = 1'b0;
        check_output("t5_clr0", {7'b0, collision}, 8'h00);
        btn_raw = 5'b00010;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check_output("t5_i2_pulse", {3'b0, key_pulse}, (e == 6) ? 8'h02 : 8'h00);
        end
        btn_raw = 5'b00011;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check_output("t5_i1_blocked", {3'b0, key_pulse}, 8'h00);
        end
        check_output("t5_coll", {7'b0, collision}, 8'h01);
        check_output("t5_busy", {7'b0, busy}, 8'h01);
        check_output("t5_level", {3'b0, key_level}, 8'h03);
        clr_collision = 1'b1;
        tick();
        clr_collision = 1'b0;
        check_output("t5_clr1", {7'b0, collision}, 8'h00);
        btn_raw = 5'b0;
        ticks(10);
        check_output("t5_idle_busy", {7'b0, busy}, 8'h00);
        btn_raw = 5'b00001;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check_output("t5_i1_pulse", {3'b0, key_pulse}, (e == 6) ? 8'h01 : 8'h00);
        end
        btn_raw = 5'b0;
        ticks(10);

        // I1 held through a reset that lands mid-count
        btn_raw = 5'b00001;
        ticks(4);
        reset = 1'b1;
        tick();
        check_all_zero("t6_rst_a");
        tick();
        check_all_zero("t6_rst_b");
        reset = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check_output("t6_pulse", {3'b0, key_pulse}, (e == 6) ? 8'h01 : 8'h00);
            check_output("t6_level", {3'b0, key_level}, (e >= 5) ? 8'h01 : 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
